// File: rtl/instr_encode_rv.sv
// rtl/instr_encode_rv.sv - RV32 field-to-instruction encoder with output FIFO and handshake counter
module instr_encode_rv #(
    parameter int DEPTH       = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   iwClk,
    input  logic                   iwRst,
    input  logic                   iwInValid,
    output logic                   owInReady,
    input  logic [2:0]             iwFormat,
    input  logic [6:0]             iwOpCode,
    input  logic [2:0]             iwFunct3,
    input  logic [6:0]             iwFunct7,
    input  logic [4:0]             iwRd,
    input  logic [4:0]             iwRs1,
    input  logic [4:0]             iwRs2,
    input  logic [31:0]            iwImmediate,
    output logic                   owOutValid,
    input  logic                   iwOutReady,
    output logic [31:0]            owInstr,
    output logic                   owError,
    output logic [COUNT_WIDTH-1:0] owCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            fill_q, fill_d;
    logic [32:0]            mem_q [DEPTH];
    logic [32:0]            mem_d [DEPTH];
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   live_q, live_d;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        push;
    logic        pop;
    logic        full;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // Sign-extension checks: every bit above the field's sign bit must match it.
    assign fits12 = (&iwImmediate[31:11]) || (~|iwImmediate[31:11]);
    assign fits13 = (&iwImmediate[31:12]) || (~|iwImmediate[31:12]);
    assign fits21 = (&iwImmediate[31:20]) || (~|iwImmediate[31:20]);

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (iwFormat)
            FMT_R: begin
                enc_word = {iwFunct7, iwRs2, iwRs1, iwFunct3, iwRd, iwOpCode};
            end
            FMT_I: begin
                enc_word = {iwImmediate[11:0], iwRs1, iwFunct3, iwRd, iwOpCode};
                enc_err  = !fits12;
            end
            FMT_S: begin
                enc_word = {iwImmediate[11:5], iwRs2, iwRs1, iwFunct3,
                            iwImmediate[4:0], iwOpCode};
                enc_err  = !fits12;
            end
            FMT_B: begin
                enc_word = {iwImmediate[12], iwImmediate[10:5], iwRs2, iwRs1, iwFunct3,
                            iwImmediate[4:1], iwImmediate[11], iwOpCode};
                enc_err  = !fits13 || iwImmediate[0];
            end
            FMT_U: begin
                enc_word = {iwImmediate[31:12], iwRd, iwOpCode};
                enc_err  = |iwImmediate[11:0];
            end
            FMT_J: begin
                enc_word = {iwImmediate[20], iwImmediate[10:1], iwImmediate[11],
                            iwImmediate[19:12], iwRd, iwOpCode};
                enc_err  = !fits21 || iwImmediate[0];
            end
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Ready comes only from flops so no path exists from iwOutReady to owInReady.
    assign full       = (fill_q == (AW+1)'(DEPTH));
    assign owInReady  = live_q && !full;
    assign owOutValid = (fill_q != '0);
    assign push       = iwInValid && owInReady;
    assign pop        = owOutValid && iwOutReady;
    assign owInstr    = owOutValid ? mem_q[rd_ptr_q][31:0] : 32'd0;
    assign owError    = owOutValid ? mem_q[rd_ptr_q][32] : 1'b0;
    assign owCount    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = 1'b1;
        fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = {enc_err, enc_word};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            live_q   <= live_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_rv.sv
// tb/tb_instr_encode_rv.sv - randomized scoreboard bench for instr_encode_rv
module tb_instr_encode_rv;

    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          iwClk = 1'b0;
    logic          iwRst = 1'b1;
    logic          iwInValid = 1'b0;
    logic          owInReady;
    logic [2:0]    iwFormat = '0;
    logic [6:0]    iwOpCode = '0;
    logic [2:0]    iwFunct3 = '0;
    logic [6:0]    iwFunct7 = '0;
    logic [4:0]    iwRd = '0;
    logic [4:0]    iwRs1 = '0;
    logic [4:0]    iwRs2 = '0;
    logic [31:0]   iwImmediate = '0;
    logic          owOutValid;
    logic          iwOutReady = 1'b0;
    logic [31:0]   owInstr;
    logic          owError;
    logic [CW-1:0] owCount;

    instr_encode_rv #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .iwClk(iwClk), .iwRst(iwRst), .iwInValid(iwInValid), .owInReady(owInReady),
        .iwFormat(iwFormat), .iwOpCode(iwOpCode), .iwFunct3(iwFunct3), .iwFunct7(iwFunct7),
        .iwRd(iwRd), .iwRs1(iwRs1), .iwRs2(iwRs2), .iwImmediate(iwImmediate),
        .owOutValid(owOutValid), .iwOutReady(iwOutReady), .owInstr(owInstr),
        .owError(owError), .owCount(owCount)
    );

    always #5 iwClk = ~iwClk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] sb[$];
    logic [CW-1:0] exp_count = '0;
    bit          rst_done = 1'b0;

    // Reference: bit placement by shift/mask arithmetic, range checks on signed integers.
    function automatic logic [32:0] model(input int unsigned fmt, input int unsigned op,
                                          input int unsigned f3, input int unsigned f7,
                                          input int unsigned rd, input int unsigned rs1,
                                          input int unsigned rs2, input int unsigned imm);
        int unsigned w;
        bit          e;
        int          si;
        si = int'(imm);
        w  = 0;
        e  = 0;
        case (fmt)
            0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            1: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = (si < -2048) || (si > 2047);
            end
            2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
                e = (si < -2048) || (si > 2047);
            end
            3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | op;
                e = (si < -4096) || (si > 4095) || (imm % 2 != 0);
            end
            4: begin
                w = (imm & 32'hFFFFF000) | (rd << 7) | op;
                e = (imm % 4096) != 0;
            end
            5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
                e = (si < -1048576) || (si > 1048575) || (imm % 2 != 0);
            end
            default: begin
                w = 0;
                e = 1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic set_bundle(input int unsigned fmt, input int unsigned op, input int unsigned f3,
                              input int unsigned f7, input int unsigned rd, input int unsigned rs1,
                              input int unsigned rs2, input int unsigned imm);
        iwFormat    = 3'(fmt);
        iwOpCode    = 7'(op);
        iwFunct3    = 3'(f3);
        iwFunct7    = 7'(f7);
        iwRd        = 5'(rd);
        iwRs1       = 5'(rs1);
        iwRs2       = 5'(rs2);
        iwImmediate = imm;
    endtask

    task automatic rand_bundle();
        int unsigned imm;
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = $urandom_range(0, 8191) - 4096;
            2: imm = $urandom_range(0, 32'h3FFFFF) - 32'h200000;
            default: imm = $urandom & 32'hFFFFF000;
        endcase
        set_bundle($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 7),
                   $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), imm);
    endtask

    // One clock of scoreboard: compare outputs at the negedge, then advance the model.
    task automatic run_cycle();
        bit          exp_ready;
        bit          exp_valid;
        bit          acc;
        bit          pop;
        logic [32:0] head;
        logic [32:0] nb;
        exp_ready = rst_done && (sb.size() < DEPTH);
        exp_valid = (sb.size() != 0);
        head      = exp_valid ? sb[0] : 33'd0;
        n_checks++;
        if (owInReady !== exp_ready) $display("FAIL in_ready got=%b exp=%b", owInReady, exp_ready);
        else n_pass++;
        n_checks++;
        if (owOutValid !== exp_valid) $display("FAIL out_valid got=%b exp=%b", owOutValid, exp_valid);
        else n_pass++;
        n_checks++;
        if (owInstr !== head[31:0]) $display("FAIL instr got=%h exp=%h", owInstr, head[31:0]);
        else n_pass++;
        n_checks++;
        if (owError !== head[32]) $display("FAIL error got=%b exp=%b", owError, head[32]);
        else n_pass++;
        n_checks++;
        if (owCount !== exp_count) $display("FAIL count got=%0d exp=%0d", owCount, exp_count);
        else n_pass++;
        acc = iwInValid && exp_ready;
        pop = exp_valid && iwOutReady;
        nb  = model(iwFormat, iwOpCode, iwFunct3, iwFunct7, iwRd, iwRs1, iwRs2, iwImmediate);
        @(posedge iwClk);
        if (pop) begin
            void'(sb.pop_front());
            exp_count++;
        end
        if (acc) sb.push_back(nb);
        @(negedge iwClk);
    endtask

    task automatic test_reset();
        iwRst     = 1'b1;
        iwInValid = 1'b0;
        @(negedge iwClk);
        @(negedge iwClk);
        n_checks++;
        if ({owOutValid, owInReady, owError, owInstr, owCount} !== '0)
            $display("FAIL reset_state got v=%b r=%b e=%b i=%h c=%0d exp all zero",
                     owOutValid, owInReady, owError, owInstr, owCount);
        else n_pass++;
        sb.delete();
        exp_count = '0;
        rst_done  = 1'b0;
        iwRst     = 1'b0;
        @(posedge iwClk);
        @(negedge iwClk);
        rst_done = 1'b1;
        n_checks++;
        if (owInReady !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", owInReady);
        else n_pass++;
    endtask

    task automatic directed(input int unsigned fmt, input int unsigned op, input int unsigned f3,
                            input int unsigned f7, input int unsigned rd, input int unsigned rs1,
                            input int unsigned rs2, input int unsigned imm,
                            input logic [31:0] exp_w, input bit chk_w, input logic exp_e);
        set_bundle(fmt, op, f3, f7, rd, rs1, rs2, imm);
        iwInValid = 1'b1;
        run_cycle();
        iwInValid = 1'b0;
        n_checks++;
        if (owOutValid !== 1'b1) $display("FAIL latency_valid fmt=%0d got=%b exp=1", fmt, owOutValid);
        else n_pass++;
        if (chk_w) begin
            n_checks++;
            if (owInstr !== exp_w) $display("FAIL plan_word fmt=%0d got=%h exp=%h", fmt, owInstr, exp_w);
            else n_pass++;
        end
        n_checks++;
        if (owError !== exp_e) $display("FAIL plan_error fmt=%0d got=%b exp=%b", fmt, owError, exp_e);
        else n_pass++;
        run_cycle();
    endtask

    task automatic test_plan_vectors();
        iwOutReady = 1'b1;
        directed(0, 32'h33, 0, 0, 3, 1, 2, 0, 32'h002081B3, 1, 1'b0);
        n_checks++;
        if (owCount !== 16'd1) $display("FAIL count_after_first got=%0d exp=1", owCount);
        else n_pass++;
        directed(1, 32'h13, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 1, 1'b0);
        directed(1, 32'h13, 0, 0, 1, 0, 0, 2048, 32'h0, 0, 1'b1);
        directed(3, 32'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 1, 1'b0);
        directed(3, 32'h63, 0, 0, 0, 1, 2, 3, 32'h0, 0, 1'b1);
        directed(5, 32'h6F, 0, 0, 1, 0, 0, 8, 32'h008000EF, 1, 1'b0);
        directed(6, 32'h33, 1, 5, 7, 8, 9, 4, 32'h00000000, 1, 1'b1);
        directed(4, 32'h37, 0, 0, 5, 0, 0, 32'h12345000, 32'h123452B7, 1, 1'b0);
        directed(4, 32'h37, 0, 0, 5, 0, 0, 32'h12345001, 32'h123452B7, 1, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [32:0] first;
        test_reset();
        iwOutReady = 1'b0;
        iwInValid  = 1'b1;
        set_bundle(0, 32'h33, 0, 0, 3, 1, 2, 0);
        first = model(0, 32'h33, 0, 0, 3, 1, 2, 0);
        run_cycle();
        set_bundle(1, 32'h13, 0, 0, 1, 0, 0, 32'hFFFFFFFF);
        run_cycle();
        set_bundle(5, 32'h6F, 0, 0, 1, 0, 0, 8);
        run_cycle();
        n_checks++;
        if (owInReady !== 1'b0) $display("FAIL full_ready got=%b exp=0", owInReady);
        else n_pass++;
        n_checks++;
        if (owInstr !== first[31:0]) $display("FAIL full_head got=%h exp=%h", owInstr, first[31:0]);
        else n_pass++;
        iwOutReady = 1'b1;
        run_cycle();
        run_cycle();
        iwInValid = 1'b0;
        run_cycle();
        run_cycle();
        n_checks++;
        if (owCount !== 16'd3 || owOutValid !== 1'b0)
            $display("FAIL bp_drain got count=%0d valid=%b exp count=3 valid=0", owCount, owOutValid);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_bundle();
            iwInValid  = ($urandom_range(0, 3) != 0);
            iwOutReady = ($urandom_range(0, 2) != 0);
            run_cycle();
        end
        iwInValid  = 1'b0;
        iwOutReady = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) run_cycle();
    endtask

    task automatic test_reset_flush();
        logic [32:0] nb;
        iwOutReady = 1'b0;
        iwInValid  = 1'b1;
        rand_bundle();
        run_cycle();
        rand_bundle();
        run_cycle();
        iwInValid = 1'b0;
        #2;
        iwRst = 1'b1;
        #1;
        n_checks++;
        if (owOutValid !== 1'b0 || owCount !== '0 || owInReady !== 1'b0 || owInstr !== '0)
            $display("FAIL async_flush got v=%b c=%0d r=%b i=%h exp 0/0/0/0",
                     owOutValid, owCount, owInReady, owInstr);
        else n_pass++;
        sb.delete();
        exp_count = '0;
        rst_done  = 1'b0;
        @(negedge iwClk);
        iwRst = 1'b0;
        @(posedge iwClk);
        @(negedge iwClk);
        rst_done   = 1'b1;
        iwOutReady = 1'b1;
        iwInValid  = 1'b1;
        set_bundle(2, 32'h23, 2, 0, 0, 10, 11, 32'hFFFFFF80);
        nb = model(2, 32'h23, 2, 0, 0, 10, 11, 32'hFFFFFF80);
        run_cycle();
        iwInValid = 1'b0;
        n_checks++;
        if (owInstr !== nb[31:0] || owError !== nb[32])
            $display("FAIL post_flush_first got=%h/%b exp=%h/%b", owInstr, owError, nb[31:0], nb[32]);
        else n_pass++;
        run_cycle();
        run_cycle();
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_backpressure();
        test_random();
        test_reset_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
